br_resolve_unit: RTL and testbench
==================================

// Module: br_resolve_unit
// PURPOSE
//  Resolution side of the 2-bit branch predictor loop. Captures the predictor's
//  taken/not-taken guess for a branch in ID, carries it with PC/target into EX,
//  compares it against the ALU's actual outcome, and produces the misprediction
//  pulse fed back to the predictor, plus pipeline flush and PC redirect.
//  Sits between the predictor, the IF/ID pipeline registers and the PC mux.
// PARAMETERS
//  ADDR_W     32  width of PC / target addresses
//  CNT_W      16  width of the branch and mispredict statistics counters
//  FLUSH_LEN  2   cycles the flush is held after a mispredict (>=1)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       asynchronous active-high reset
//  stall        in   1       pipeline stall; freezes all state
//  is_br_id     in   1       ID stage holds a conditional branch
//  br_pre_id    in   1       predictor guess for that branch (1 = taken)
//  br_pc_id     in   ADDR_W  PC of the ID-stage branch
//  br_tgt_id    in   ADDR_W  computed taken target of the ID-stage branch
//  br_taken_ex  in   1       actual outcome, valid when EX slot holds a branch
//  pre_wrong    out  1       mispredict pulse to predictor
//  flush        out  1       kill IF and ID stages
//  redirect_vld out  1       PC mux selects redirect_pc
//  redirect_pc  out  ADDR_W  corrected fetch address
//  br_cnt       out  CNT_W   resolved branches (saturating)
//  mis_cnt      out  CNT_W   mispredicted branches (saturating)
// BEHAVIOUR
//  Reset (async, any cycle, incl. mid-flush): EX slot invalid, FSM=RUN, flush
//   counter 0, both counters 0; all outputs 0 in the reset cycle and after.
//  EX slot capture (posedge, !stall): ex_vld <= is_br_id & ~flush & ~mis;
//   ex_pred, ex_pc, ex_tgt <= br_pre_id, br_pc_id, br_tgt_id. stall=1 holds all.
//  mis = ex_vld & ~stall & (br_taken_ex != ex_pred)   (combinational)
//  pre_wrong = mis (same cycle, one-cycle pulse per branch, never under stall).
//  redirect_vld = mis; redirect_pc = br_taken_ex ? ex_tgt : ex_pc + 4
//   (ADDR_W arithmetic, wraps modulo 2^ADDR_W). redirect_pc = 0 when !mis.
//  FSM RUN: flush = mis. On mis -> FLUSH, fcnt <= FLUSH_LEN-1.
//      If FLUSH_LEN==1 stay RUN.
//  FSM FLUSH: flush = 1; when !stall: fcnt==0 -> RUN, else fcnt--.
//   stall freezes fcnt. Branches in ID while flush=1 are wrong-path: not
//   captured, not counted. No new mis can occur in FLUSH (EX slot is invalid).
//  Simultaneous mis and is_br_id: ID branch is dropped (wrong path).
//  Counters (posedge, !stall): br_cnt++ when ex_vld; mis_cnt++ when mis;
//   each saturates at all-ones; mis_cnt <= br_cnt always.
//  Correct prediction: no outputs asserted; slot simply refills/empties.
// TESTING
//  1 rst=1 mid-FLUSH with fcnt=1 -> all outputs 0 immediately; after release,
//    a correct branch produces no flush and br_cnt=1, mis_cnt=0.
//  2 ID branch pc=0x100, tgt=0x140, pred=0; next cycle br_taken_ex=1 ->
//    pre_wrong=flush=redirect_vld=1, redirect_pc=0x140; flush held 2 cycles.
//  3 pc=0x200 pred=1, actual 0 -> redirect_pc=0x204; pc=0xFFFFFFFC pred=1,
//    actual 0 -> redirect_pc=0x0 (wrap).
//  4 mispredict resolving while stall=1 for 3 cycles -> pre_wrong/flush stay 0
//    until the first !stall cycle, then exactly one pulse; counters +1 once.
//  5 back-to-back branches, second in ID on mis cycle -> second not captured,
//    br_cnt +1 only; then 2^CNT_W+3 mispredicts -> mis_cnt stays 0xFFFF.

Source files
------------

// File: rtl/br_resolve_unit.sv
// Branch resolution: compares predicted vs actual outcome in EX and drives
// the mispredict pulse, IF/ID flush, PC redirect and branch statistics.
module br_resolve_unit #(
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int FLUSH_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              is_br_id,
    input  logic              br_pre_id,
    input  logic [ADDR_W-1:0] br_pc_id,
    input  logic [ADDR_W-1:0] br_tgt_id,
    input  logic              br_taken_ex,
    output logic              pre_wrong,
    output logic              flush,
    output logic              redirect_vld,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mis_cnt
);

    localparam int FCNT_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam logic [FCNT_W-1:0] FCNT_INIT = FCNT_W'(FLUSH_LEN - 1);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    typedef struct packed {
        logic              vld;
        logic              pred;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] tgt;
    } ex_slot_t;

    ex_slot_t          ex_q;
    state_t            state_q;
    state_t            state_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;
    logic              mis;

    // A stalled EX stage never resolves, so the pulse waits for release
    assign mis = ex_q.vld & ~stall & (br_taken_ex != ex_q.pred);

    assign pre_wrong    = mis;
    assign redirect_vld = mis;

    always_comb begin
        redirect_pc = '0;
        if (mis) begin
            redirect_pc = br_taken_ex ? ex_q.tgt : ex_q.pc + ADDR_W'(4);
        end
    end

    // Wrong-path branches (under flush or on the mispredict cycle) are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (!stall) begin
            ex_q.vld  <= is_br_id & ~flush & ~mis;
            ex_q.pred <= br_pre_id;
            ex_q.pc   <= br_pc_id;
            ex_q.tgt  <= br_tgt_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        flush   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                flush = mis;
                if (mis && (FLUSH_LEN > 1)) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FCNT_INIT;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (!stall) begin
                    if (fcnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else if (!stall) begin
            if (ex_q.vld && (br_cnt != '1)) begin
                br_cnt <= br_cnt + 1'b1;
            end
            if (mis && (mis_cnt != '1)) begin
                mis_cnt <= mis_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_br_resolve_unit.sv
// Directed bench for br_resolve_unit: a default instance plus a narrow
// counter instance sharing the same stimulus for saturation checks.
module tb_br_resolve_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        is_br_id;
    logic        br_pre_id;
    logic [31:0] br_pc_id;
    logic [31:0] br_tgt_id;
    logic        br_taken_ex;

    logic        pre_wrong;
    logic        flush;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic [15:0] br_cnt;
    logic [15:0] mis_cnt;

    logic        s_pre_wrong;
    logic        s_flush;
    logic        s_redirect_vld;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_br_cnt;
    logic [3:0]  s_mis_cnt;

    int vecs = 0;
    int errs = 0;

    br_resolve_unit u_dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .is_br_id     (is_br_id),
        .br_pre_id    (br_pre_id),
        .br_pc_id     (br_pc_id),
        .br_tgt_id    (br_tgt_id),
        .br_taken_ex  (br_taken_ex),
        .pre_wrong    (pre_wrong),
        .flush        (flush),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .br_cnt       (br_cnt),
        .mis_cnt      (mis_cnt)
    );

    br_resolve_unit #(.CNT_W(4)) u_sat (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .is_br_id     (is_br_id),
        .br_pre_id    (br_pre_id),
        .br_pc_id     (br_pc_id),
        .br_tgt_id    (br_tgt_id),
        .br_taken_ex  (br_taken_ex),
        .pre_wrong    (s_pre_wrong),
        .flush        (s_flush),
        .redirect_vld (s_redirect_vld),
        .redirect_pc  (s_redirect_pc),
        .br_cnt       (s_br_cnt),
        .mis_cnt      (s_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        is_br_id    = 1'b0;
        br_pre_id   = 1'b0;
        br_pc_id    = '0;
        br_tgt_id   = '0;
        br_taken_ex = 1'b0;
        stall       = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pred);
        is_br_id  = 1'b1;
        br_pre_id = pred;
        br_pc_id  = pc;
        br_tgt_id = tgt;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        #1;
        vecs++;
        if ({pre_wrong, flush, redirect_vld, redirect_pc, br_cnt, mis_cnt} !== '0) begin
            errs++;
            $display("FAIL reset_outs: got pw=%b fl=%b rv=%b pc=%h bc=%0d mc=%0d want all 0",
                     pre_wrong, flush, redirect_vld, redirect_pc, br_cnt, mis_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        @(negedge clk); idle(); issue(32'h100, 32'h140, 1'b0);
        @(negedge clk); idle(); br_taken_ex = 1'b1;
        @(negedge clk); idle(); #1;
        vecs++;
        if (flush !== 1'b1) begin
            errs++; $display("FAIL t1_in_flush: got %b want 1", flush);
        end
        rst = 1'b1;
        #1;
        vecs++;
        if ({pre_wrong, flush, redirect_vld, redirect_pc, br_cnt, mis_cnt} !== '0) begin
            errs++;
            $display("FAIL t1_async_rst: got pw=%b fl=%b rv=%b pc=%h bc=%0d mc=%0d want all 0",
                     pre_wrong, flush, redirect_vld, redirect_pc, br_cnt, mis_cnt);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk); issue(32'h180, 32'h1c0, 1'b1);
        @(negedge clk); idle(); br_taken_ex = 1'b1; #1;
        vecs++;
        if ({pre_wrong, flush, redirect_vld} !== 3'b000) begin
            errs++; $display("FAIL t1_correct: got %b want 000", {pre_wrong, flush, redirect_vld});
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (br_cnt !== 16'd1 || mis_cnt !== 16'd0) begin
            errs++; $display("FAIL t1_counts: got %0d/%0d want 1/0", br_cnt, mis_cnt);
        end
    endtask

    task automatic test_mispredict_taken();
        @(negedge clk); idle(); issue(32'h100, 32'h140, 1'b0); #1;
        vecs++;
        if (flush !== 1'b0) begin
            errs++; $display("FAIL t2_pre_flush: got %b want 0", flush);
        end
        @(negedge clk); idle(); br_taken_ex = 1'b1; #1;
        vecs++;
        if ({pre_wrong, flush, redirect_vld} !== 3'b111) begin
            errs++; $display("FAIL t2_pulse: got %b want 111", {pre_wrong, flush, redirect_vld});
        end
        vecs++;
        if (redirect_pc !== 32'h140) begin
            errs++; $display("FAIL t2_rpc: got %h want 00000140", redirect_pc);
        end
        @(negedge clk); idle(); issue(32'h600, 32'h640, 1'b0); #1;
        vecs++;
        if ({pre_wrong, flush, redirect_vld} !== 3'b010 || redirect_pc !== 32'h0) begin
            errs++;
            $display("FAIL t2_hold1: got %b pc=%h want 010 pc=0",
                     {pre_wrong, flush, redirect_vld}, redirect_pc);
        end
        @(negedge clk); idle(); br_taken_ex = 1'b1; #1;
        vecs++;
        if ({pre_wrong, flush} !== 2'b01) begin
            errs++; $display("FAIL t2_hold2: got %b want 01", {pre_wrong, flush});
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (flush !== 1'b0 || br_cnt !== 16'd2 || mis_cnt !== 16'd1) begin
            errs++;
            $display("FAIL t2_end: got fl=%b %0d/%0d want fl=0 2/1", flush, br_cnt, mis_cnt);
        end
    endtask

    task automatic test_not_taken_wrap();
        @(negedge clk); idle(); issue(32'h200, 32'h300, 1'b1);
        @(negedge clk); idle(); #1;
        vecs++;
        if (pre_wrong !== 1'b1 || redirect_pc !== 32'h204) begin
            errs++; $display("FAIL t3_nt: got pw=%b pc=%h want 1 00000204", pre_wrong, redirect_pc);
        end
        repeat (2) @(negedge clk);
        @(negedge clk); idle(); issue(32'hFFFF_FFFC, 32'h10, 1'b1);
        @(negedge clk); idle(); #1;
        vecs++;
        if (redirect_vld !== 1'b1 || redirect_pc !== 32'h0) begin
            errs++; $display("FAIL t3_wrap: got rv=%b pc=%h want 1 00000000", redirect_vld, redirect_pc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stall();
        @(negedge clk); idle(); issue(32'h400, 32'h480, 1'b0); #1;
        vecs++;
        if (br_cnt !== 16'd4 || mis_cnt !== 16'd3) begin
            errs++; $display("FAIL t4_pre_counts: got %0d/%0d want 4/3", br_cnt, mis_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle(); stall = 1'b1; br_taken_ex = 1'b1; #1;
            vecs++;
            if ({pre_wrong, flush, redirect_vld} !== 3'b000) begin
                errs++;
                $display("FAIL t4_stalled%0d: got %b want 000", i, {pre_wrong, flush, redirect_vld});
            end
        end
        @(negedge clk); idle(); br_taken_ex = 1'b1; #1;
        vecs++;
        if (pre_wrong !== 1'b1 || flush !== 1'b1 || redirect_pc !== 32'h480 || br_cnt !== 16'd4) begin
            errs++;
            $display("FAIL t4_release: got pw=%b fl=%b pc=%h bc=%0d want 1 1 00000480 4",
                     pre_wrong, flush, redirect_pc, br_cnt);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (pre_wrong !== 1'b0 || flush !== 1'b1 || br_cnt !== 16'd5 || mis_cnt !== 16'd4) begin
            errs++;
            $display("FAIL t4_once: got pw=%b fl=%b %0d/%0d want 0 1 5/4",
                     pre_wrong, flush, br_cnt, mis_cnt);
        end
        @(negedge clk); idle();
    endtask

    task automatic test_drop_on_mis();
        @(negedge clk); idle(); issue(32'h500, 32'h540, 1'b0);
        @(negedge clk); idle(); issue(32'h510, 32'h550, 1'b0); br_taken_ex = 1'b1; #1;
        vecs++;
        if (pre_wrong !== 1'b1) begin
            errs++; $display("FAIL t5_first_mis: got %b want 1", pre_wrong);
        end
        @(negedge clk); idle(); br_taken_ex = 1'b1; #1;
        vecs++;
        if (pre_wrong !== 1'b0) begin
            errs++; $display("FAIL t5_dropped: got %b want 0", pre_wrong);
        end
        @(negedge clk); idle();
        @(negedge clk); idle(); #1;
        vecs++;
        if (flush !== 1'b0 || br_cnt !== 16'd6 || mis_cnt !== 16'd5) begin
            errs++;
            $display("FAIL t5_counts: got fl=%b %0d/%0d want 0 6/5", flush, br_cnt, mis_cnt);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); idle(); issue(32'h700, 32'h740, 1'b1);
        @(negedge clk); idle(); issue(32'h704, 32'h780, 1'b0); br_taken_ex = 1'b1; #1;
        vecs++;
        if ({pre_wrong, flush, redirect_vld, redirect_pc} !== '0) begin
            errs++; $display("FAIL b2b_first: got pw=%b fl=%b want 0 0", pre_wrong, flush);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if ({pre_wrong, flush, redirect_vld, redirect_pc} !== '0) begin
            errs++; $display("FAIL b2b_second: got pw=%b fl=%b want 0 0", pre_wrong, flush);
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (br_cnt !== 16'd8 || mis_cnt !== 16'd5) begin
            errs++; $display("FAIL b2b_counts: got %0d/%0d want 8/5", br_cnt, mis_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk); idle(); issue(32'h800 + 32'(i * 4), 32'h900, 1'b0);
            @(negedge clk); idle(); br_taken_ex = 1'b1;
            @(negedge clk); idle();
            @(negedge clk); idle();
        end
        @(negedge clk); idle(); #1;
        vecs++;
        if (s_mis_cnt !== 4'hF) begin
            errs++; $display("FAIL sat_mis: got %h want f", s_mis_cnt);
        end
        vecs++;
        if (s_br_cnt !== 4'hF) begin
            errs++; $display("FAIL sat_br: got %h want f", s_br_cnt);
        end
        vecs++;
        if (br_cnt !== 16'd27 || mis_cnt !== 16'd24) begin
            errs++; $display("FAIL sat_wide: got %0d/%0d want 27/24", br_cnt, mis_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_reset_mid_flush();
        test_mispredict_taken();
        test_not_taken_wrap();
        test_stall();
        test_drop_on_mis();
        test_back_to_back();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
